// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C command arbiter.
package i2c_arb_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 24;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Next requester index after idx, wrapping n-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Scan offsets 0..NREQ-1 from ptr; the lowest offset with a request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_vld && req[j] &&
            ((int'(ptr) + k == j) || (int'(ptr) + k == j + NREQ))) begin
          gnt_vld   = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master between NREQ requesters with round-robin grant.
// Optional watchdog: define I2C_ARB_WATCHDOG_EN to build the TIMEOUT counter.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no owner; grant first valid requester at/after rr_ptr
// ST_ISSUE   | command presented to master, waiting for m_cmd_ready
// ST_BUSY    | master executing, data routed to owner, wait for finish
// ST_RELEASE | one idle cycle, advance rr_ptr past the owner
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_cmd_vld,
  input  logic [CMD_W*NREQ-1:0]  req_cmd,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [LEN_W*NREQ-1:0]  req_burst_len,
  output logic [NREQ-1:0]        req_cmd_ready,
  output logic [NREQ-1:0]        req_cmd_finish,
  input  logic [NREQ-1:0]        req_wr_vld,
  input  logic [DATA_W*NREQ-1:0] req_wr_data,
  output logic [NREQ-1:0]        req_wr_ready,
  output logic [NREQ-1:0]        req_rd_vld,
  output logic [DATA_W*NREQ-1:0] req_rd_data,
  input  logic [NREQ-1:0]        req_rd_ready,
  output logic                   m_cmd_vld,
  output logic [CMD_W-1:0]       m_cmd,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [LEN_W-1:0]       m_burst_len,
  input  logic                   m_cmd_ready,
  input  logic                   m_cmd_finish,
  output logic                   m_wr_vld,
  output logic [DATA_W-1:0]      m_wr_data,
  input  logic                   m_wr_ready,
  input  logic                   m_rd_vld,
  input  logic [DATA_W-1:0]      m_rd_data,
  output logic                   m_rd_ready,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic                   timeout_err
);

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [CMD_W-1:0]  sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              xfer;
  logic              done_ok;
  logic              wd_expire;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_cmd_vld),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign xfer    = (state == ST_ISSUE) || (state == ST_BUSY);
  assign done_ok = ((state == ST_BUSY) && m_cmd_finish) ||
                   ((state == ST_ISSUE) && m_cmd_ready && m_cmd_finish);

  // Select the winning requester's command fields for capture.
  always_comb begin
    sel_cmd  = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_cmd  = req_cmd[i*CMD_W +: CMD_W];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_burst_len[i*LEN_W +: LEN_W];
      end
    end
  end

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire   = xfer && (wd_cnt == WD_W'(TIMEOUT)) && !done_ok;
  assign timeout_err = wd_expire && !rst;

  // Watchdog counts cycles spent in ISSUE/BUSY; restarts on each state entry.
  always_ff @(posedge clock) begin
    if (rst || !xfer || ((state == ST_ISSUE) && m_cmd_ready)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Capture handshake and completion pulses; suppressed while rst is high
  // so a reset mid-transfer never reports a finish.
  always_comb begin
    req_cmd_ready  = '0;
    req_cmd_finish = '0;
    if (!rst && (state == ST_IDLE)) begin
      req_cmd_ready = gnt_oh;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && (done_ok || wd_expire) && (owner == IDX_W'(i))) begin
        req_cmd_finish[i] = 1'b1;
      end
    end
  end

  // Byte streams connect only the owner to the master during a transfer.
  always_comb begin
    m_wr_vld     = 1'b0;
    m_wr_data    = '0;
    req_wr_ready = '0;
    req_rd_vld   = '0;
    req_rd_data  = '0;
    m_rd_ready   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && (owner == IDX_W'(i))) begin
        m_wr_vld                         = req_wr_vld[i];
        m_wr_data                        = req_wr_data[i*DATA_W +: DATA_W];
        req_wr_ready[i]                  = m_wr_ready;
        req_rd_vld[i]                    = m_rd_vld;
        req_rd_data[i*DATA_W +: DATA_W]  = m_rd_data;
        m_rd_ready                       = req_rd_ready[i];
      end
    end
  end

  // Arbitration FSM with registered command, owner and busy outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      m_cmd_vld   <= 1'b0;
      m_cmd       <= '0;
      m_addr      <= '0;
      m_burst_len <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner       <= gnt_idx;
            m_cmd       <= sel_cmd;
            m_addr      <= sel_addr;
            m_burst_len <= sel_len;
            m_cmd_vld   <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wd_expire) begin
            m_cmd_vld <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_RELEASE;
          end else if (m_cmd_ready) begin
            m_cmd_vld <= 1'b0;
            if (m_cmd_finish) begin
              busy  <= 1'b0;
              state <= ST_RELEASE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (done_ok || wd_expire) begin
            busy  <= 1'b0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rr_ptr <= wrap_inc(owner, NREQ);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: table of grant transactions plus
// hand sequences for data routing, reset mid-transfer and the watchdog.
module tb_i2c_cmd_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_cmd_vld;
  logic [4*NREQ-1:0]    req_cmd;
  logic [16*NREQ-1:0]   req_addr;
  logic [24*NREQ-1:0]   req_burst_len;
  logic [NREQ-1:0]      req_cmd_ready;
  logic [NREQ-1:0]      req_cmd_finish;
  logic [NREQ-1:0]      req_wr_vld;
  logic [8*NREQ-1:0]    req_wr_data;
  logic [NREQ-1:0]      req_wr_ready;
  logic [NREQ-1:0]      req_rd_vld;
  logic [8*NREQ-1:0]    req_rd_data;
  logic [NREQ-1:0]      req_rd_ready;
  logic                 m_cmd_vld;
  logic [3:0]           m_cmd;
  logic [15:0]          m_addr;
  logic [23:0]          m_burst_len;
  logic                 m_cmd_ready;
  logic                 m_cmd_finish;
  logic                 m_wr_vld;
  logic [7:0]           m_wr_data;
  logic                 m_wr_ready;
  logic                 m_rd_vld;
  logic [7:0]           m_rd_data;
  logic                 m_rd_ready;
  logic [2:0]           owner;
  logic                 busy;
  logic                 timeout_err;

  int n_run  = 0;
  int n_fail = 0;

  i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .rst            (rst),
    .req_cmd_vld    (req_cmd_vld),
    .req_cmd        (req_cmd),
    .req_addr       (req_addr),
    .req_burst_len  (req_burst_len),
    .req_cmd_ready  (req_cmd_ready),
    .req_cmd_finish (req_cmd_finish),
    .req_wr_vld     (req_wr_vld),
    .req_wr_data    (req_wr_data),
    .req_wr_ready   (req_wr_ready),
    .req_rd_vld     (req_rd_vld),
    .req_rd_data    (req_rd_data),
    .req_rd_ready   (req_rd_ready),
    .m_cmd_vld      (m_cmd_vld),
    .m_cmd          (m_cmd),
    .m_addr         (m_addr),
    .m_burst_len    (m_burst_len),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_finish   (m_cmd_finish),
    .m_wr_vld       (m_wr_vld),
    .m_wr_data      (m_wr_data),
    .m_wr_ready     (m_wr_ready),
    .m_rd_vld       (m_rd_vld),
    .m_rd_data      (m_rd_data),
    .m_rd_ready     (m_rd_ready),
    .owner          (owner),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  mask;
    int          exp_idx;
    logic [3:0]  exp_cmd;
    logic [15:0] exp_addr;
    logic [23:0] exp_len;
    int          ready_dly;
    bit          fin_in_issue;
  } txn_t;

  txn_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Grant requester idx (must be next in round-robin order) and enter BUSY.
  task automatic grant_to(input int idx);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    req_cmd_vld = oh;
    tick();
    req_cmd_vld = '0;
    chk("grant_owner", 64'(owner), 64'(idx));
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
  endtask

  task automatic finish_txn();
    m_cmd_finish = 1'b1;
    tick();
    m_cmd_finish = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] exp_oh;

    // requester constants: r0 cmd3/0010/1, r1 cmd2/0051/2, r2 cmd1/00A0/3, r3 cmd5/1234/0x100
    req_cmd       = {4'h5, 4'h1, 4'h2, 4'h3};
    req_addr      = {16'h1234, 16'h00A0, 16'h0051, 16'h0010};
    req_burst_len = {24'h000100, 24'd3, 24'd2, 24'd1};

    tbl[0] = '{4'b1011, 0, 4'h3, 16'h0010, 24'd1, 0, 1'b0};
    tbl[1] = '{4'b1010, 1, 4'h2, 16'h0051, 24'd2, 2, 1'b0};
    tbl[2] = '{4'b1000, 3, 4'h5, 16'h1234, 24'h000100, 0, 1'b1};
    tbl[3] = '{4'b1111, 0, 4'h3, 16'h0010, 24'd1, 1, 1'b0};
    tbl[4] = '{4'b1110, 1, 4'h2, 16'h0051, 24'd2, 0, 1'b0};
    tbl[5] = '{4'b0101, 2, 4'h1, 16'h00A0, 24'd3, 0, 1'b1};
    tbl[6] = '{4'b0101, 0, 4'h3, 16'h0010, 24'd1, 0, 1'b0};
    tbl[7] = '{4'b0100, 2, 4'h1, 16'h00A0, 24'd3, 0, 1'b0};
    tbl[8] = '{4'b0100, 2, 4'h1, 16'h00A0, 24'd3, 0, 1'b0};

    rst          = 1'b1;
    req_cmd_vld  = '0;
    req_wr_vld   = '0;
    req_wr_data  = '0;
    req_rd_ready = '0;
    m_cmd_ready  = 1'b0;
    m_cmd_finish = 1'b0;
    m_wr_ready   = 1'b0;
    m_rd_vld     = 1'b0;
    m_rd_data    = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_m_cmd_vld", 64'(m_cmd_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_burst_len", 64'(m_burst_len), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_finish", 64'(req_cmd_finish), 64'd0);

    for (int t = 0; t < 9; t++) begin
      exp_oh = 4'(1 << tbl[t].exp_idx);
      req_cmd_vld = tbl[t].mask;
      #1;
      chk("idle_ready", 64'(req_cmd_ready), 64'(exp_oh));
      chk("idle_busy", 64'(busy), 64'd0);
      tick();
      chk("issue_vld", 64'(m_cmd_vld), 64'd1);
      chk("issue_owner", 64'(owner), 64'(tbl[t].exp_idx));
      chk("issue_cmd", 64'(m_cmd), 64'(tbl[t].exp_cmd));
      chk("issue_addr", 64'(m_addr), 64'(tbl[t].exp_addr));
      chk("issue_len", 64'(m_burst_len), 64'(tbl[t].exp_len));
      chk("issue_busy", 64'(busy), 64'd1);
      req_cmd_vld = tbl[t].mask & ~exp_oh;
      #1;
      chk("issue_no_ready", 64'(req_cmd_ready), 64'd0);
      for (int d = 0; d < tbl[t].ready_dly; d++) begin
        tick();
        chk("issue_hold_vld", 64'(m_cmd_vld), 64'd1);
        chk("issue_hold_addr", 64'(m_addr), 64'(tbl[t].exp_addr));
      end
      m_cmd_ready  = 1'b1;
      m_cmd_finish = tbl[t].fin_in_issue;
      #1;
      chk("issue_finish", 64'(req_cmd_finish), tbl[t].fin_in_issue ? 64'(exp_oh) : 64'd0);
      tick();
      m_cmd_ready  = 1'b0;
      m_cmd_finish = 1'b0;
      if (!tbl[t].fin_in_issue) begin
        chk("busy_vld_low", 64'(m_cmd_vld), 64'd0);
        chk("busy_busy", 64'(busy), 64'd1);
        tick();
        m_cmd_finish = 1'b1;
        #1;
        chk("busy_finish", 64'(req_cmd_finish), 64'(exp_oh));
        tick();
        m_cmd_finish = 1'b0;
      end
      #1;
      chk("release_busy", 64'(busy), 64'd0);
      chk("release_no_grant", 64'(req_cmd_ready), 64'd0);
      chk("release_finish", 64'(req_cmd_finish), 64'd0);
      tick();
    end

    // write routing: owner 1, requester 0 also presenting data
    m_wr_ready  = 1'b1;
    req_wr_vld  = 4'b0011;
    req_wr_data = {8'h00, 8'h00, 8'h55, 8'h77};
    #1;
    chk("idle_wr_ready", 64'(req_wr_ready), 64'd0);
    chk("idle_m_wr_vld", 64'(m_wr_vld), 64'd0);
    grant_to(1);
    #1;
    chk("wr_m_vld", 64'(m_wr_vld), 64'd1);
    chk("wr_data_55", 64'(m_wr_data), 64'h55);
    chk("wr_ready_vec", 64'(req_wr_ready), 64'b0010);
    tick();
    req_wr_data[15:8] = 8'hAA;
    #1;
    chk("wr_data_aa", 64'(m_wr_data), 64'hAA);
    chk("wr_ready_vec2", 64'(req_wr_ready), 64'b0010);
    req_wr_vld = 4'b0001;
    #1;
    chk("wr_nonowner_ignored", 64'(m_wr_vld), 64'd0);
    req_wr_vld = '0;
    m_wr_ready = 1'b0;
    finish_txn();

    // read routing: owner 3
    grant_to(3);
    m_rd_vld     = 1'b1;
    m_rd_data    = 8'h3C;
    req_rd_ready = 4'b1000;
    #1;
    chk("rd_vld_vec", 64'(req_rd_vld), 64'b1000);
    chk("rd_data3", 64'(req_rd_data[31:24]), 64'h3C);
    chk("rd_m_ready", 64'(m_rd_ready), 64'd1);
    req_rd_ready = 4'b0111;
    #1;
    chk("rd_m_ready_nonowner", 64'(m_rd_ready), 64'd0);

    // reset while BUSY: finish arriving alongside rst must not be reported
    rst          = 1'b1;
    m_cmd_finish = 1'b1;
    #1;
    chk("rst_busy_no_finish", 64'(req_cmd_finish), 64'd0);
    tick();
    rst          = 1'b0;
    m_cmd_finish = 1'b0;
    #1;
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_owner", 64'(owner), 64'd0);
    chk("rst2_rd_vld", 64'(req_rd_vld), 64'd0);
    chk("rst2_m_rd_ready", 64'(m_rd_ready), 64'd0);
    chk("rst2_m_addr", 64'(m_addr), 64'd0);
    chk("rst2_finish", 64'(req_cmd_finish), 64'd0);
    m_rd_vld     = 1'b0;
    m_rd_data    = '0;
    req_rd_ready = '0;

    // watchdog: master never finishes
    grant_to(0);
`ifdef I2C_ARB_WATCHDOG_EN
    for (int c = 0; c < TIMEOUT; c++) begin
      chk("wd_early", 64'(timeout_err), 64'd0);
      tick();
    end
    chk("wd_pulse", 64'(timeout_err), 64'd1);
    chk("wd_finish", 64'(req_cmd_finish), 64'b0001);
    tick();
    chk("wd_release_err", 64'(timeout_err), 64'd0);
    chk("wd_release_busy", 64'(busy), 64'd0);
    tick();
    req_cmd_vld = 4'b0010;
    #1;
    chk("wd_idle_grant", 64'(req_cmd_ready), 64'b0010);
    req_cmd_vld = '0;
`else
    for (int c = 0; c < TIMEOUT + 4; c++) begin
      chk("nowd_err", 64'(timeout_err), 64'd0);
      chk("nowd_busy", 64'(busy), 64'd1);
      tick();
    end
    finish_txn();
    chk("nowd_done_busy", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one I2C master (2..8).
REQ-002 Parameter TIMEOUT, default 1_000_000, watchdog limit in clock cycles.
REQ-003 clock  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_cmd_vld  in  NREQ  per-requester command valid.
REQ-006 req_cmd  in  4*NREQ  per-requester command, slice i = [4i+3:4i].
REQ-007 req_addr  in  16*NREQ  per-requester slave/register address.
REQ-008 req_burst_len  in  24*NREQ  per-requester burst length.
REQ-009 req_cmd_ready  out  NREQ  one-cycle capture acknowledge.
REQ-010 req_cmd_finish  out  NREQ  one-cycle completion pulse to owner.
REQ-011 req_wr_vld / req_wr_data  in  NREQ / 8*NREQ  write byte streams.
REQ-012 req_wr_ready  out  NREQ  write ready.
REQ-013 req_rd_vld / req_rd_data  out  NREQ / 8*NREQ  read byte streams.
REQ-014 req_rd_ready  in  NREQ  read ready.
REQ-015 m_cmd_vld, m_cmd[3:0], m_addr[15:0], m_burst_len[23:0]  out  command to master.
REQ-016 m_cmd_ready, m_cmd_finish  in  1 each  master handshake and completion.
REQ-017 m_wr_vld, m_wr_data[7:0] out; m_wr_ready in  master write port.
REQ-018 m_rd_vld, m_rd_data[7:0] in; m_rd_ready out  master read port.
REQ-019 owner  out  3  index of current owner; busy  out  1; timeout_err  out  1.

Function
REQ-020 States IDLE, ISSUE, BUSY, RELEASE; encoded as a package enum.
REQ-021 IDLE: when any req_cmd_vld is high, grant the first requester at or after rr_ptr (round-robin, wraps NREQ-1 to 0), capture its cmd/addr/burst_len into registers, pulse its req_cmd_ready, go to ISSUE.
REQ-022 ISSUE: m_cmd_vld=1 with captured fields, held stable until m_cmd_ready; on handshake go to BUSY.
REQ-023 Latency: m_cmd_vld rises exactly one cycle after the granting req_cmd_vld is sampled in IDLE.
REQ-024 BUSY: on m_cmd_finish pulse req_cmd_finish[owner] the same cycle (combinational from registered state), go to RELEASE.
REQ-025 RELEASE: one cycle, rr_ptr <= owner+1 mod NREQ, busy drops, return to IDLE; no grant in RELEASE.
REQ-026 m_cmd_finish arriving in ISSUE together with m_cmd_ready: handshake and finish both honoured, go directly to RELEASE.
REQ-027 Data routing only in ISSUE/BUSY: m_wr_vld=req_wr_vld[owner], req_wr_ready[i]=m_wr_ready&&(i==owner); req_rd_vld[i]=m_rd_vld&&(i==owner), m_rd_ready=req_rd_ready[owner]; all zero otherwise.
REQ-028 Non-owners see req_cmd_ready=0 while busy; their requests wait, never dropped.
REQ-029 busy=1 in ISSUE, BUSY; owner holds last granted index until next grant.
REQ-030 Single requester repeated: regranted after one RELEASE cycle (two-cycle gap minimum).

Reset
REQ-031 rst: state=IDLE, rr_ptr=0, owner=0, captured fields=0, all outputs 0, timeout counter=0.
REQ-032 rst mid-transfer abandons the grant; no req_cmd_finish is emitted.

Configuration
REQ-033 With I2C_ARB_WATCHDOG_EN defined: a counter runs in ISSUE/BUSY, clears on state entry; reaching TIMEOUT forces RELEASE, pulses timeout_err and req_cmd_finish[owner] for one cycle.
REQ-034 Without I2C_ARB_WATCHDOG_EN: no counter is built, timeout_err tied 0, BUSY waits indefinitely.

Structure
REQ-035 Package i2c_arb_pkg holds state enum, field widths (CMD_W=4, ADDR_W=16, LEN_W=24, DATA_W=8).
REQ-036 Sub-module rr_arbiter (NREQ-wide request vector, pointer in, one-hot and index grant out), combinational.

Verification
REQ-037 Req 2 only, cmd=4'h1, addr=16'h00A0, len=3 -> m_cmd_vld next cycle with those values, owner=2, req_cmd_ready[2] one pulse.
REQ-038 Reqs 0,1,3 simultaneously, rr_ptr=0 -> grants in order 0,1,3, each after prior req_cmd_finish, then rr_ptr=0.
REQ-039 Owner=1 writing bytes 8'h55,8'hAA with m_wr_ready=1 -> only req_wr_ready[1] high; req 0 wr_vld ignored.
REQ-040 Master returns rd byte 8'h3C while owner=3 -> req_rd_vld[3]=1, data 8'h3C; other rd_vld 0.
REQ-041 Watchdog on, TIMEOUT=16, m_cmd_finish never arrives -> timeout_err pulse 16 cycles after BUSY entry, state IDLE two cycles later.
REQ-042 rst asserted in BUSY -> next cycle all outputs 0, no req_cmd_finish pulse.
